seg7_scan_capture: RTL and testbench
====================================

# seg7_scan_capture

Receive-side counterpart of the BCD-to-seven-segment encoder. Monitors a multiplexed seven-segment display bus (one-hot digit anodes plus the shared `{a,b,c,d,e,f,g,dp}` segment lines) and decodes each scanned segment pattern back into a 4-bit BCD code per digit. Each captured value is qualified by a stability filter. A frame-complete pulse is raised once every digit position has been captured. Used for display readback, self-check, and bench scoreboarding of the display path.

## Interface
- `NUM_DIGITS`, 4, number of scanned digit positions (2..8)
- `STABLE_CYCLES`, 4, consecutive identical synchronized samples required before a capture (2..255)
- `AN_ACTIVE_LOW`, 1, 1 = anode lines active-low, 0 = active-high

- `clk` in 1: single clock
- `rst_n` in 1: reset, asynchronous, active-low
- `an` in NUM_DIGITS: digit enables; bit i selects digit i
- `seg` in 8: segment lines `{a,b,c,d,e,f,g,dp}`, active-high (bit7 = a, bit0 = dp)
- `digits` out 4*NUM_DIGITS: captured codes; digit i occupies `[4i+3:4i]`
- `dp_out` out NUM_DIGITS: captured decimal-point bit per digit
- `digit_err` out NUM_DIGITS: 1 = last capture for digit i was an illegal pattern
- `frame_valid` out 1: one-cycle pulse when every digit has been captured since the last pulse

## Operation
- **Input synchronization:** `an` and `seg` pass through 2-flop synchronizers. The anode synchronizer flops reset to the inactive level.
- **Anode normalization:** `an` is normalized by `AN_ACTIVE_LOW`.
  - Exactly one bit active: the sample is valid, with index `idx`.
  - Zero or multiple bits active: the sample is invalid.
- **State machine:** three states.
  - IDLE: no valid sample. Go to SETTLE on a valid sample, with count = 1.
  - SETTLE: counting. If the sample `{idx, seg}` equals the previous sample, increment the count. If it differs but is valid, restart at count = 1. If it is invalid, go to IDLE. When the count reaches STABLE_CYCLES, perform one capture and go to HELD.
  - HELD: no further capture while the sample is unchanged. If the sample changes and is valid, go to SETTLE with count = 1. If it becomes invalid, go to IDLE.
- **Decode of `seg[7:1]`:**
  - Patterns 0..9 (`1111110`, `0110000`, `1101101`, `1111001`, `0110011`, `1011011`, `1011111`, `1110000`, `1111111`, `1111011`) give BCD 0..9 with err = 0.
  - `0000000` (blank) gives `4'hF` with err = 0.
  - Any other pattern gives `4'hE` with err = 1.
  - `dp_out[idx]` is set to `seg[0]` regardless of the decode result.
- **Capture:** writes `digits[idx]`, `dp_out[idx]` and `digit_err[idx]`, and sets bit `idx` of an internal seen-mask. Re-capturing a digit already in the mask only updates its value.
- **Frame completion:** when the mask becomes all ones, `frame_valid` pulses for one cycle and the mask clears in that same cycle.
- **Capture coinciding with `frame_valid`:** a capture in the same cycle as the `frame_valid` pulse sets its mask bit in the freshly cleared mask; the bit is not lost.
- **Counter width:** the counter saturates and is sized to hold STABLE_CYCLES; it never wraps.

## Timing
- **Reset values:**
  - `digits` = all `4'hF`
  - `dp_out` = 0
  - `digit_err` = 0
  - `frame_valid` = 0
  - seen-mask = 0
  - state = IDLE
  - count = 0
- **Reset mid-operation:** applies immediately (asynchronously) and discards any partial dwell or partial frame.
- **Capture latency:** pins stable from edge k result in updated `digits` and `dp_out` visible after edge k+2+STABLE_CYCLES (6 cycles with defaults).
  - 2 cycles are synchronizer delay.
  - STABLE_CYCLES cycles are the filter; the capture register is updated on the clock edge that ends the STABLE_CYCLES-th identical sample.
- **`frame_valid` timing:** asserted in the first cycle in which the completing capture is visible on `digits`.
- **Glitch rejection:** a dwell shorter than STABLE_CYCLES synchronized cycles produces no capture.
- **Minimum scan dwell:** STABLE_CYCLES+2 cycles per digit.
- **Outputs:** all registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert `rst_n` = 0 for 3 cycles, release, hold `an` = 4'b1111 -> `digits` = 16'hFFFF, `dp_out` = 0, `digit_err` = 0, `frame_valid` never pulses.
- **Full scan:** scan digits 0..3 showing 1, 2, 3, 4 (`an` = 1110, 1101, 1011, 0111), 10 cycles each -> `digits` = 16'h4321. Exactly one `frame_valid` pulse, 6 cycles after `an` = 0111 is applied. A second identical scan produces another single pulse.
- **Glitch rejection:** on digit 1, hold pattern "7" for 3 cycles, then "8" for 10 cycles -> `digits[7:4]` goes directly to 8 and never to 7. Capture occurs 6 cycles after "8" is applied.
- **Illegal and blank patterns:**
  - Digit 2 with `seg` = 8'b10000001 -> `digits[11:8]` = E, `digit_err[2]` = 1, `dp_out[2]` = 1.
  - Then `seg` = 8'b00000000 -> `digits[11:8]` = F, `digit_err[2]` = 0, `dp_out[2]` = 0.
- **Invalid anodes:** `an` = 1100 (two digits active) held 20 cycles with `seg` = "5" -> no capture, `digits` unchanged, state stays IDLE. Then `an` = 1110 -> digit 0 = 5 after 6 cycles.
- **Reset mid-operation:** assert reset after digits 0..2 of a scan are captured and 2 cycles into digit 3 -> outputs return to reset values in the same cycle. After release, scanning only digit 3 does not produce `frame_valid`.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: reads back a multiplexed 7-segment bus and
// recovers one BCD code, decimal point and error flag per digit.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   an           digit anodes (one-hot, polarity by AN_ACTIVE_LOW)
//   seg          {a,b,c,d,e,f,g,dp}, active-high
//   digits       captured codes, digit i at [4i+3:4i]
//   dp_out       captured decimal point per digit
//   digit_err    last capture of digit i was an illegal pattern
//   frame_valid  1-cycle pulse once every digit has been captured
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [7:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = IW + 8;

  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q;
  logic [7:0]              seg_s1_q, seg_s2_q;
  logic [SW-1:0]           prev_q;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dp_q, err_q;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    fv_q, fv_d;

  logic [NUM_DIGITS-1:0] act;
  logic                  valid;
  logic [IW-1:0]         idx;
  logic [SW-1:0]         sample;
  logic                  same;
  logic                  cap;
  logic [3:0]            dec_code;
  logic                  dec_err;

  // Two-flop synchronizers; anodes park at the inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q  <= AN_OFF;
      an_s2_q  <= AN_OFF;
      seg_s1_q <= '0;
      seg_s2_q <= '0;
    end else begin
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
    end
  end

  assign act   = an_s2_q ^ AN_OFF;
  assign valid = $onehot(act);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (act[i]) idx = IW'(i);
    end
  end

  assign sample = {idx, seg_s2_q};
  assign same   = (sample == prev_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end
      end
      SETTLE: begin
        if (!valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          cnt_d = CNT_ONE;
        end else if (cnt_q >= CNT_MAX - CNT_ONE) begin
          // This edge ends the last required sample.
          cap     = 1'b1;
          state_d = HELD;
          cnt_d   = CNT_MAX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= sample;
    end
  end

  always_comb begin
    dec_err = 1'b0;
    case (seg_s2_q[7:1])
      7'b1111110: dec_code = 4'd0;
      7'b0110000: dec_code = 4'd1;
      7'b1101101: dec_code = 4'd2;
      7'b1111001: dec_code = 4'd3;
      7'b0110011: dec_code = 4'd4;
      7'b1011011: dec_code = 4'd5;
      7'b1011111: dec_code = 4'd6;
      7'b1110000: dec_code = 4'd7;
      7'b1111111: dec_code = 4'd8;
      7'b1111011: dec_code = 4'd9;
      7'b0000000: dec_code = 4'hF;
      default: begin
        dec_code = 4'hE;
        dec_err  = 1'b1;
      end
    endcase
  end

  // The completing capture clears the mask on the same edge it
  // raises frame_valid, so the next capture lands in a clean mask.
  always_comb begin
    mask_d = mask_q;
    fv_d   = 1'b0;
    if (cap) begin
      mask_d = mask_q | act;
      if (&mask_d) begin
        fv_d   = 1'b1;
        mask_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '1;
      dp_q     <= '0;
      err_q    <= '0;
      mask_q   <= '0;
      fv_q     <= 1'b0;
    end else begin
      mask_q <= mask_d;
      fv_q   <= fv_d;
      if (cap) begin
        digits_q[{idx, 2'b00} +: 4] <= dec_code;
        dp_q[idx]  <= seg_s2_q[0];
        err_q[idx] <= dec_err;
      end
    end
  end

  assign digits      = digits_q;
  assign dp_out      = dp_q;
  assign digit_err   = err_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scenarios plus random
// scanning, compared every cycle against a run-length model.
module tb_seg7_scan_capture;

  localparam int ND = 4;
  localparam int S  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [15:0] digits;
  logic [3:0]  dp_out;
  logic [3:0]  digit_err;
  logic        frame_valid;

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .NUM_DIGITS(ND),
    .STABLE_CYCLES(S),
    .AN_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .an(an),
    .seg(seg),
    .digits(digits),
    .dp_out(dp_out),
    .digit_err(digit_err),
    .frame_valid(frame_valid)
  );

  logic [6:0] PAT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011
  };

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int last_fv_cyc = -1;
  bit track7 = 0;
  bit saw7 = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // Reference model: pins reach the filter two edges late; a
  // capture fires when a valid sample has been seen exactly S
  // times in a row.
  logic [3:0] h1a, h2a, pa, ca;
  logic [7:0] h1s, h2s, ps, cs;
  int         run;
  logic [3:0] md [4];
  logic [3:0] mdp, merr, mmask;
  logic       mfv;
  logic [4:0] dv;

  function automatic logic [4:0] mdec(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (PAT[i] == p) return {1'b0, 4'(i)};
    if (p == 7'd0) return 5'h0F;
    return 5'h1E;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1a = 4'hF; h2a = 4'hF; pa = 4'hF;
      h1s = 8'h0; h2s = 8'h0; ps = 8'h0;
      run = 0;
      for (int i = 0; i < 4; i++) md[i] = 4'hF;
      mdp = 0; merr = 0; mmask = 0; mfv = 0;
    end else begin
      ca = h2a; cs = h2s;
      h2a = h1a; h2s = h1s;
      h1a = an;  h1s = seg;
      mfv = 0;
      if ($countones(~ca) != 1) run = 0;
      else if (run > 0 && ca == pa && cs == ps)
        run = (run < 1000) ? run + 1 : run;
      else run = 1;
      pa = ca; ps = cs;
      if (run == S) begin
        dv = mdec(cs[7:1]);
        for (int i = 0; i < 4; i++) begin
          if (!ca[i]) begin
            md[i] = dv[3:0];
            merr[i] = dv[4];
            mdp[i] = cs[0];
            mmask[i] = 1'b1;
          end
        end
        if (mmask == 4'hF) begin
          mfv = 1;
          mmask = 0;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("digits", 32'(digits), {md[3], md[2], md[1], md[0]});
    chk("dp_out", 32'(dp_out), 32'(mdp));
    chk("digit_err", 32'(digit_err), 32'(merr));
    chk("frame_valid", 32'(frame_valid), 32'(mfv));
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      last_fv_cyc = cyc;
    end
    if (track7 && digits[7:4] == 4'd7) saw7 = 1;
  end

  task automatic hold(input logic [3:0] a,
                      input logic [7:0] s,
                      input int n);
    an = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sv(input int d, input bit dp);
    return {PAT[d], dp};
  endfunction

  task automatic full_scan;
    int f0, c0;
    logic [3:0] one;
    f0 = fv_cnt;
    c0 = 0;
    for (int i = 0; i < 4; i++) begin
      one = 4'b0001 << i;
      if (i == 3) c0 = cyc;
      hold(~one, sv(i + 1, 0), 10);
    end
    chk("scan_digits", 32'(digits), 32'h4321);
    chk("scan_pulses", fv_cnt - f0, 1);
    chk("scan_fv_lat", last_fv_cyc - c0, 6);
  endtask

  initial begin
    int f0, r;
    logic [15:0] save;
    logic [3:0] a, one;
    logic [7:0] s;
    rst_n = 0;
    an = 4'hF;
    seg = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    hold(4'b1111, sv(8, 1), 10);
    chk("rst_digits", 32'(digits), 32'hFFFF);
    chk("rst_dp", 32'(dp_out), 0);
    chk("rst_err", 32'(digit_err), 0);
    chk("rst_pulses", fv_cnt, 0);

    full_scan();
    full_scan();

    track7 = 1;
    hold(4'b1101, sv(7, 0), 3);
    hold(4'b1101, sv(8, 0), 5);
    chk("glitch_early", 32'(digits[7:4]), 2);
    hold(4'b1101, sv(8, 0), 1);
    chk("glitch_cap", 32'(digits[7:4]), 8);
    hold(4'b1101, sv(8, 0), 4);
    track7 = 0;
    chk("glitch_no7", 32'(saw7), 0);

    hold(4'b1011, 8'b10000001, 10);
    chk("ill_code", 32'(digits[11:8]), 32'hE);
    chk("ill_err", 32'(digit_err[2]), 1);
    chk("ill_dp", 32'(dp_out[2]), 1);
    hold(4'b1011, 8'b00000000, 10);
    chk("blank_code", 32'(digits[11:8]), 32'hF);
    chk("blank_err", 32'(digit_err[2]), 0);
    chk("blank_dp", 32'(dp_out[2]), 0);

    save = digits;
    hold(4'b1100, sv(5, 0), 20);
    chk("inv_hold", 32'(digits), 32'(save));
    hold(4'b1110, sv(5, 0), 6);
    chk("inv_then_d0", 32'(digits[3:0]), 5);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      one = 4'b0001 << $urandom_range(0, 3);
      a = (r < 8) ? ~one : 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) s = sv($urandom_range(0, 9), 1'($urandom));
      else if (r == 7) s = {7'd0, 1'($urandom)};
      else s = 8'($urandom);
      hold(a, s, $urandom_range(1, 12));
    end

    hold(4'b1110, sv(7, 0), 10);
    hold(4'b1101, sv(8, 0), 10);
    hold(4'b1011, sv(9, 0), 10);
    chk("pre_rst", 32'(digits[11:0]), 32'h987);
    hold(4'b0111, sv(1, 0), 2);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_digits", 32'(digits), 32'hFFFF);
    chk("mid_rst_dp", 32'(dp_out), 0);
    chk("mid_rst_fv", 32'(frame_valid), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    f0 = fv_cnt;
    hold(4'b0111, sv(6, 1), 20);
    chk("post_rst_nofv", fv_cnt - f0, 0);
    chk("post_rst_dig", 32'(digits), 32'h6FFF);
    chk("post_rst_dp", 32'(dp_out), 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
